fifo_v4: RTL and testbench

- Multi-channel successor of the single-queue FIFO: NUM_CH independent circular queues in one block, each with its own push/pop/flush, status and error flags.
- Adds programmable almost-full/almost-empty thresholds, a full-width usage count, sticky overflow/underflow flags, and push-on-full-with-pop acceptance.
- Used wherever the MPT walker and checker need per-hart or per-requester request/response buffering with back-pressure.

---
 rtl/fifo_v4_pkg.sv | 28 ++
 rtl/fifo_v4_ch.sv | 116 +++++++++++
 rtl/fifo_v4.sv | 76 +++++++
 tb/tb_fifo_v4.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_v4_pkg.sv
// Shared definitions for the multi-channel FIFO.
//   calc_addr_depth : pointer width for a given depth (min 1 bit)
//   depth_ok/th_ok  : elaboration-time parameter sanity checks
//   ch_status_t     : per-channel status flags bundled by the channel
package fifo_v4_pkg;

    function automatic int unsigned calc_addr_depth(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit depth_ok(input int unsigned depth);
        return depth >= 1;
    endfunction

    function automatic bit th_ok(input int unsigned th, input int unsigned depth);
        return th <= depth;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic alm_full;
        logic alm_empty;
        logic ovf;
        logic udf;
    } ch_status_t;

endpackage

// File: rtl/fifo_v4_ch.sv
// One independent circular queue.
//   clk_i, rst_ni      : clock, async active-low reset
//   flush_i            : synchronous flush (beats push/pop)
//   push_i, data_i     : push strobe and data
//   pop_i, data_o      : pop strobe and head entry
//   usage_o            : exact entry count 0..DEPTH
//   status_o           : full/empty/almost/sticky error flags
module fifo_v4_ch
    import fifo_v4_pkg::*;
#(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ALM_FULL_TH  = DEPTH - 1,
    parameter int unsigned ALM_EMPTY_TH = 1,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = calc_addr_depth(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  dtype                  data_i,
    input  logic                  pop_i,
    output dtype                  data_o,
    output logic [ADDR_DEPTH:0]   usage_o,
    output ch_status_t            status_o
);

    localparam logic [ADDR_DEPTH-1:0] LP_PTR_MAX = ADDR_DEPTH'(DEPTH - 1);
    localparam logic [ADDR_DEPTH:0]   LP_DEPTH   = (ADDR_DEPTH+1)'(DEPTH);
    localparam logic [ADDR_DEPTH:0]   LP_AF_TH   = (ADDR_DEPTH+1)'(ALM_FULL_TH);
    localparam logic [ADDR_DEPTH:0]   LP_AE_TH   = (ADDR_DEPTH+1)'(ALM_EMPTY_TH);
    localparam logic [ADDR_DEPTH:0]   LP_ONE     = (ADDR_DEPTH+1)'(1);

    dtype                  r_mem [DEPTH];
    logic [ADDR_DEPTH-1:0] r_wptr;
    logic [ADDR_DEPTH-1:0] r_rptr;
    logic [ADDR_DEPTH:0]   r_cnt;
    logic                  r_ovf;
    logic                  r_udf;

    logic w_full;
    logic w_cnt_zero;
    logic w_bypass;
    logic w_bypass_pop;
    logic w_empty;
    logic w_wr_en;
    logic w_rd_en;
    logic w_ovf_evt;
    logic w_udf_evt;

    function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] ptr);
        return (ptr == LP_PTR_MAX) ? '0 : ptr + ADDR_DEPTH'(1);
    endfunction

    assign w_full     = (r_cnt == LP_DEPTH);
    assign w_cnt_zero = (r_cnt == '0);

    // Fall-through: a push into an empty queue is presented on data_o at once.
    // If it is popped in the same cycle it never touches the storage.
    assign w_bypass     = FALL_THROUGH && w_cnt_zero && push_i;
    assign w_bypass_pop = w_bypass && pop_i;
    assign w_empty      = w_cnt_zero && !w_bypass;

    assign w_wr_en   = push_i && (!w_full || pop_i) && !w_bypass_pop && !flush_i;
    assign w_rd_en   = pop_i && !w_empty && !w_bypass_pop && !flush_i;
    assign w_ovf_evt = push_i && w_full && !pop_i;
    assign w_udf_evt = pop_i && w_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else begin
            if (w_wr_en) r_wptr <= ptr_inc(r_wptr);
            if (w_rd_en) r_rptr <= ptr_inc(r_rptr);
            case ({w_wr_en, w_rd_en})
                2'b10:   r_cnt <= r_cnt + LP_ONE;
                2'b01:   r_cnt <= r_cnt - LP_ONE;
                default: r_cnt <= r_cnt;
            endcase
            if (w_ovf_evt) r_ovf <= 1'b1;
            if (w_udf_evt) r_udf <= 1'b1;
        end
    end

    // Storage is not cleared by flush, only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
        end else if (w_wr_en) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    assign data_o  = w_bypass ? data_i : r_mem[r_rptr];
    assign usage_o = r_cnt;

    assign status_o.full      = w_full;
    assign status_o.empty     = w_empty;
    assign status_o.alm_full  = (r_cnt >= LP_AF_TH);
    assign status_o.alm_empty = (r_cnt <= LP_AE_TH);
    assign status_o.ovf       = r_ovf;
    assign status_o.udf       = r_udf;

endmodule

// File: rtl/fifo_v4.sv
// Multi-channel FIFO: NUM_CH independent queues with per-channel
// push/pop/flush, occupancy, almost-full/empty and sticky error flags.
//   clk_i, rst_ni            : clock, async active-low reset
//   flush_i/push_i/pop_i     : per-channel strobes
//   data_i/data_o            : per-channel push data / head entry
//   full_o/empty_o           : per-channel fill status
//   almost_full_o/_empty_o   : usage vs programmable thresholds
//   usage_o                  : per-channel entry count 0..DEPTH
//   overflow_o/underflow_o   : sticky dropped-push / empty-pop flags
module fifo_v4
    import fifo_v4_pkg::*;
#(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned NUM_CH       = 1,
    parameter int unsigned ALM_FULL_TH  = DEPTH - 1,
    parameter int unsigned ALM_EMPTY_TH = 1,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = calc_addr_depth(DEPTH)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_CH-1:0]                 flush_i,
    input  logic [NUM_CH-1:0]                 push_i,
    input  dtype [NUM_CH-1:0]                 data_i,
    input  logic [NUM_CH-1:0]                 pop_i,
    output dtype [NUM_CH-1:0]                 data_o,
    output logic [NUM_CH-1:0]                 full_o,
    output logic [NUM_CH-1:0]                 empty_o,
    output logic [NUM_CH-1:0]                 almost_full_o,
    output logic [NUM_CH-1:0]                 almost_empty_o,
    output logic [NUM_CH-1:0][ADDR_DEPTH:0]   usage_o,
    output logic [NUM_CH-1:0]                 overflow_o,
    output logic [NUM_CH-1:0]                 underflow_o
);

    if (!depth_ok(DEPTH)) begin : g_err_depth
        $error("fifo_v4: DEPTH must be >= 1");
    end
    if (!th_ok(ALM_FULL_TH, DEPTH) || !th_ok(ALM_EMPTY_TH, DEPTH)) begin : g_err_th
        $error("fifo_v4: almost-full/empty thresholds must not exceed DEPTH");
    end

    for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
        ch_status_t w_status;

        fifo_v4_ch #(
            .FALL_THROUGH (FALL_THROUGH),
            .DATA_WIDTH   (DATA_WIDTH),
            .DEPTH        (DEPTH),
            .ALM_FULL_TH  (ALM_FULL_TH),
            .ALM_EMPTY_TH (ALM_EMPTY_TH),
            .dtype        (dtype),
            .ADDR_DEPTH   (ADDR_DEPTH)
        ) u_ch (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .flush_i  (flush_i[g]),
            .push_i   (push_i[g]),
            .data_i   (data_i[g]),
            .pop_i    (pop_i[g]),
            .data_o   (data_o[g]),
            .usage_o  (usage_o[g]),
            .status_o (w_status)
        );

        assign full_o[g]         = w_status.full;
        assign empty_o[g]        = w_status.empty;
        assign almost_full_o[g]  = w_status.alm_full;
        assign almost_empty_o[g] = w_status.alm_empty;
        assign overflow_o[g]     = w_status.ovf;
        assign underflow_o[g]    = w_status.udf;
    end

endmodule

// File: tb/tb_fifo_v4.sv
module tb_fifo_v4;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=4, two channels, thresholds 3/1
    logic [1:0]      d4_flush, d4_push, d4_pop;
    logic [1:0][7:0] d4_din, d4_dout;
    logic [1:0]      d4_full, d4_empty, d4_af, d4_ae, d4_ovf, d4_udf;
    logic [1:0][2:0] d4_usage;

    // DEPTH=5, one channel
    logic [0:0]      d5_flush, d5_push, d5_pop;
    logic [0:0][7:0] d5_din, d5_dout;
    logic [0:0]      d5_full, d5_empty, d5_af, d5_ae, d5_ovf, d5_udf;
    logic [0:0][3:0] d5_usage;

    // DEPTH=4, one channel, fall-through
    logic [0:0]      ft_flush, ft_push, ft_pop;
    logic [0:0][7:0] ft_din, ft_dout;
    logic [0:0]      ft_full, ft_empty, ft_af, ft_ae, ft_ovf, ft_udf;
    logic [0:0][2:0] ft_usage;

    fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4), .NUM_CH(2),
              .ALM_FULL_TH(3), .ALM_EMPTY_TH(1)) u_d4 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(d4_flush), .push_i(d4_push),
        .data_i(d4_din), .pop_i(d4_pop), .data_o(d4_dout), .full_o(d4_full),
        .empty_o(d4_empty), .almost_full_o(d4_af), .almost_empty_o(d4_ae),
        .usage_o(d4_usage), .overflow_o(d4_ovf), .underflow_o(d4_udf));

    fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(5), .NUM_CH(1)) u_d5 (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(d5_flush), .push_i(d5_push),
        .data_i(d5_din), .pop_i(d5_pop), .data_o(d5_dout), .full_o(d5_full),
        .empty_o(d5_empty), .almost_full_o(d5_af), .almost_empty_o(d5_ae),
        .usage_o(d5_usage), .overflow_o(d5_ovf), .underflow_o(d5_udf));

    fifo_v4 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4), .NUM_CH(1)) u_ft (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(ft_flush), .push_i(ft_push),
        .data_i(ft_din), .pop_i(ft_pop), .data_o(ft_dout), .full_o(ft_full),
        .empty_o(ft_empty), .almost_full_o(ft_af), .almost_empty_o(ft_ae),
        .usage_o(ft_usage), .overflow_o(ft_ovf), .underflow_o(ft_udf));

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one queue per channel; 0,1 = d4 ch0/ch1, 2 = d5, 3 = ft
    int unsigned mq [4][$];
    bit mo [4];
    bit mu [4];
    int md [4]  = '{4, 4, 5, 4};
    bit mft [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    task automatic model_upd(input int k, input bit push, input bit pop,
                             input bit flush, input int unsigned data);
        int sz;
        sz = mq[k].size();
        if (flush) begin
            mq[k].delete();
            mo[k] = 1'b0;
            mu[k] = 1'b0;
            return;
        end
        if (mft[k] && sz == 0 && push) begin
            if (!pop) mq[k].push_back(data);
            return;
        end
        if (pop && sz == 0) mu[k] = 1'b1;
        if (push && sz == md[k] && !pop) mo[k] = 1'b1;
        if (pop && sz > 0) void'(mq[k].pop_front());
        if (push && (sz < md[k] || pop)) mq[k].push_back(data);
    endtask

    task automatic clear_inputs();
        d4_flush = '0; d4_push = '0; d4_pop = '0; d4_din = '0;
        d5_flush = '0; d5_push = '0; d5_pop = '0; d5_din = '0;
        ft_flush = '0; ft_push = '0; ft_pop = '0; ft_din = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        for (int c = 0; c < 2; c++) model_upd(c, d4_push[c], d4_pop[c], d4_flush[c], d4_din[c]);
        model_upd(2, d5_push[0], d5_pop[0], d5_flush[0], d5_din[0]);
        model_upd(3, ft_push[0], ft_pop[0], ft_flush[0], ft_din[0]);
        @(negedge clk);
        clear_inputs();
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            n_vec++;
            if ({d4_full[c], d4_empty[c], d4_af[c], d4_ae[c], d4_ovf[c], d4_udf[c]} !== 6'b010100) begin
                n_err++;
                $display("FAIL reset_flags ch%0d got=%b exp=010100", c,
                         {d4_full[c], d4_empty[c], d4_af[c], d4_ae[c], d4_ovf[c], d4_udf[c]});
            end
            n_vec++;
            if (d4_usage[c] !== 3'd0 || d4_dout[c] !== 8'h00) begin
                n_err++;
                $display("FAIL reset_usage_data ch%0d usage=%0d data=%h exp 0/00", c, d4_usage[c], d4_dout[c]);
            end
        end
        n_vec++;
        if (d5_empty[0] !== 1'b1 || ft_empty[0] !== 1'b1 || d5_usage[0] !== 4'd0) begin
            n_err++;
            $display("FAIL reset_other d5_empty=%b ft_empty=%b d5_usage=%0d exp 1/1/0",
                     d5_empty[0], ft_empty[0], d5_usage[0]);
        end
    endtask

    task automatic test_fill_drain();
        bit [4:0] ae_tab = 5'b00011;
        bit [4:0] af_tab = 5'b11000;
        for (int i = 0; i <= 4; i++) begin
            n_vec++;
            if (d4_usage[0] !== 3'(i) || d4_ae[0] !== ae_tab[i] || d4_af[0] !== af_tab[i]) begin
                n_err++;
                $display("FAIL fill_status usage=%0d ae=%b af=%b exp usage=%0d ae=%b af=%b",
                         d4_usage[0], d4_ae[0], d4_af[0], i, ae_tab[i], af_tab[i]);
            end
            if (i < 4) begin
                d4_push[0] = 1'b1;
                d4_din[0]  = 8'hA0 + 8'(i);
                tick();
            end
        end
        n_vec++;
        if (d4_full[0] !== 1'b1 || d4_empty[1] !== 1'b1 || d4_usage[1] !== 3'd0) begin
            n_err++;
            $display("FAIL fill_full full0=%b empty1=%b usage1=%0d exp 1/1/0",
                     d4_full[0], d4_empty[1], d4_usage[1]);
        end
        for (int i = 0; i < 4; i++) begin
            d4_pop[0] = 1'b1;
            #1;
            n_vec++;
            if (d4_dout[0] !== 8'hA0 + 8'(i)) begin
                n_err++;
                $display("FAIL drain_data got=%h exp=%h", d4_dout[0], 8'hA0 + 8'(i));
            end
            tick();
        end
        n_vec++;
        if (d4_empty[0] !== 1'b1 || d4_usage[0] !== 3'd0) begin
            n_err++;
            $display("FAIL drain_empty empty=%b usage=%0d exp 1/0", d4_empty[0], d4_usage[0]);
        end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp_seq [4];
        exp_seq = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
        for (int i = 0; i < 4; i++) begin
            d4_push[0] = 1'b1;
            d4_din[0]  = 8'hA0 + 8'(i);
            tick();
        end
        d4_push[0] = 1'b1; d4_din[0] = 8'hB0; d4_pop[0] = 1'b1;
        #1;
        n_vec++;
        if (d4_dout[0] !== 8'hA0) begin
            n_err++;
            $display("FAIL pushpop_full_head got=%h exp=a0", d4_dout[0]);
        end
        tick();
        n_vec++;
        if (d4_usage[0] !== 3'd4 || d4_ovf[0] !== 1'b0 || d4_full[0] !== 1'b1) begin
            n_err++;
            $display("FAIL pushpop_full_state usage=%0d ovf=%b full=%b exp 4/0/1",
                     d4_usage[0], d4_ovf[0], d4_full[0]);
        end
        d4_push[0] = 1'b1; d4_din[0] = 8'hC0;
        tick();
        n_vec++;
        if (d4_ovf[0] !== 1'b1 || d4_usage[0] !== 3'd4 || d4_dout[0] !== 8'hA1) begin
            n_err++;
            $display("FAIL overflow_set ovf=%b usage=%0d head=%h exp 1/4/a1",
                     d4_ovf[0], d4_usage[0], d4_dout[0]);
        end
        tick();
        n_vec++;
        if (d4_ovf[0] !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_sticky ovf=%b exp=1", d4_ovf[0]);
        end
        for (int i = 0; i < 4; i++) begin
            d4_pop[0] = 1'b1;
            #1;
            n_vec++;
            if (d4_dout[0] !== exp_seq[i]) begin
                n_err++;
                $display("FAIL full_drain_data idx=%0d got=%h exp=%h", i, d4_dout[0], exp_seq[i]);
            end
            tick();
        end
        d4_pop[0] = 1'b1;
        tick();
        n_vec++;
        if (d4_udf[0] !== 1'b1 || d4_usage[0] !== 3'd0 || d4_ae[0] !== 1'b1) begin
            n_err++;
            $display("FAIL underflow udf=%b usage=%0d ae=%b exp 1/0/1", d4_udf[0], d4_usage[0], d4_ae[0]);
        end
    endtask

    task automatic test_flush();
        d4_pop[1] = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            d4_push[1] = 1'b1;
            d4_din[1]  = 8'($urandom);
            tick();
        end
        d4_push[1] = 1'b1; d4_din[1] = 8'hEE;
        tick();
        d4_pop[1] = 1'b1;
        tick();
        n_vec++;
        if (d4_usage[1] !== 3'd3 || d4_ovf[1] !== 1'b1 || d4_udf[1] !== 1'b1) begin
            n_err++;
            $display("FAIL preflush usage=%0d ovf=%b udf=%b exp 3/1/1", d4_usage[1], d4_ovf[1], d4_udf[1]);
        end
        d4_flush[1] = 1'b1; d4_push[1] = 1'b1; d4_din[1] = 8'h99;
        d4_push[0]  = 1'b1; d4_din[0]  = 8'h77;
        tick();
        n_vec++;
        if (d4_usage[1] !== 3'd0 || d4_empty[1] !== 1'b1 || d4_ovf[1] !== 1'b0 || d4_udf[1] !== 1'b0) begin
            n_err++;
            $display("FAIL flush_ch1 usage=%0d empty=%b ovf=%b udf=%b exp 0/1/0/0",
                     d4_usage[1], d4_empty[1], d4_ovf[1], d4_udf[1]);
        end
        n_vec++;
        if (d4_usage[0] !== 3'd1 || d4_ovf[0] !== 1'b1 || d4_udf[0] !== 1'b1 || d4_dout[0] !== 8'h77) begin
            n_err++;
            $display("FAIL flush_ch0_untouched usage=%0d ovf=%b udf=%b data=%h exp 1/1/1/77",
                     d4_usage[0], d4_ovf[0], d4_udf[0], d4_dout[0]);
        end
        d4_push[1] = 1'b1; d4_din[1] = 8'h5A;
        tick();
        n_vec++;
        if (d4_usage[1] !== 3'd1 || d4_dout[1] !== 8'h5A) begin
            n_err++;
            $display("FAIL postflush_push usage=%0d data=%h exp 1/5a", d4_usage[1], d4_dout[1]);
        end
    endtask

    task automatic test_wrap_d5();
        for (int i = 0; i < 3; i++) begin
            d5_push[0] = 1'b1;
            d5_din[0]  = 8'($urandom);
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            d5_push[0] = 1'b1; d5_pop[0] = 1'b1; d5_din[0] = 8'($urandom);
            #1;
            n_vec++;
            if (d5_dout[0] !== 8'(mq[2][0])) begin
                n_err++;
                $display("FAIL wrap_data step=%0d got=%h exp=%h", i, d5_dout[0], 8'(mq[2][0]));
            end
            tick();
            n_vec++;
            if (d5_usage[0] !== 4'd3) begin
                n_err++;
                $display("FAIL wrap_usage step=%0d got=%0d exp=3", i, d5_usage[0]);
            end
        end
    endtask

    task automatic test_fall_through();
        ft_push[0] = 1'b1; ft_pop[0] = 1'b1; ft_din[0] = 8'h55;
        #1;
        n_vec++;
        if (ft_dout[0] !== 8'h55 || ft_empty[0] !== 1'b0) begin
            n_err++;
            $display("FAIL ft_bypass data=%h empty=%b exp 55/0", ft_dout[0], ft_empty[0]);
        end
        tick();
        n_vec++;
        if (ft_usage[0] !== 3'd0 || ft_empty[0] !== 1'b1 || ft_udf[0] !== 1'b0) begin
            n_err++;
            $display("FAIL ft_bypass_after usage=%0d empty=%b udf=%b exp 0/1/0",
                     ft_usage[0], ft_empty[0], ft_udf[0]);
        end
        ft_push[0] = 1'b1; ft_din[0] = 8'h66;
        tick();
        n_vec++;
        if (ft_usage[0] !== 3'd1 || ft_dout[0] !== 8'h66) begin
            n_err++;
            $display("FAIL ft_store usage=%0d data=%h exp 1/66", ft_usage[0], ft_dout[0]);
        end
        ft_pop[0] = 1'b1;
        tick();
        ft_pop[0] = 1'b1;
        tick();
        n_vec++;
        if (ft_usage[0] !== 3'd0 || ft_udf[0] !== 1'b1) begin
            n_err++;
            $display("FAIL ft_underflow usage=%0d udf=%b exp 0/1", ft_usage[0], ft_udf[0]);
        end
    endtask

    task automatic test_random();
        int sz;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 2; c++) begin
                d4_push[c]  = 1'($urandom_range(1, 0));
                d4_pop[c]   = 1'($urandom_range(1, 0));
                d4_flush[c] = ($urandom_range(31, 0) == 0);
                d4_din[c]   = 8'($urandom);
            end
            d5_push[0] = 1'($urandom_range(1, 0)); d5_pop[0] = 1'($urandom_range(1, 0));
            d5_din[0]  = 8'($urandom);
            ft_push[0] = 1'($urandom_range(1, 0)); ft_pop[0] = 1'($urandom_range(1, 0));
            ft_flush[0] = ($urandom_range(31, 0) == 0);
            ft_din[0]  = 8'($urandom);
            #1;
            for (int c = 0; c < 2; c++) begin
                sz = mq[c].size();
                n_vec++;
                if (d4_usage[c] !== 3'(sz) || d4_full[c] !== (sz == 4) || d4_empty[c] !== (sz == 0) ||
                    d4_af[c] !== (sz >= 3) || d4_ae[c] !== (sz <= 1) ||
                    d4_ovf[c] !== mo[c] || d4_udf[c] !== mu[c] ||
                    (sz > 0 && d4_dout[c] !== 8'(mq[c][0]))) begin
                    n_err++;
                    $display("FAIL rand_d4 cyc=%0d ch%0d usage=%0d f=%b e=%b af=%b ae=%b o=%b u=%b d=%h exp usage=%0d o=%b u=%b",
                             n, c, d4_usage[c], d4_full[c], d4_empty[c], d4_af[c], d4_ae[c],
                             d4_ovf[c], d4_udf[c], d4_dout[c], sz, mo[c], mu[c]);
                end
            end
            sz = mq[2].size();
            n_vec++;
            if (d5_usage[0] !== 4'(sz) || d5_full[0] !== (sz == 5) || d5_ovf[0] !== mo[2] ||
                d5_udf[0] !== mu[2] || (sz > 0 && d5_dout[0] !== 8'(mq[2][0]))) begin
                n_err++;
                $display("FAIL rand_d5 cyc=%0d usage=%0d full=%b o=%b u=%b d=%h exp usage=%0d o=%b u=%b",
                         n, d5_usage[0], d5_full[0], d5_ovf[0], d5_udf[0], d5_dout[0], sz, mo[2], mu[2]);
            end
            sz = mq[3].size();
            n_vec++;
            if (ft_usage[0] !== 3'(sz) || ft_empty[0] !== (sz == 0 && !ft_push[0]) ||
                ft_ovf[0] !== mo[3] || ft_udf[0] !== mu[3] ||
                (sz > 0 && ft_dout[0] !== 8'(mq[3][0])) ||
                (sz == 0 && ft_push[0] && ft_dout[0] !== ft_din[0])) begin
                n_err++;
                $display("FAIL rand_ft cyc=%0d usage=%0d empty=%b o=%b u=%b d=%h exp usage=%0d o=%b u=%b",
                         n, ft_usage[0], ft_empty[0], ft_ovf[0], ft_udf[0], ft_dout[0], sz, mo[3], mu[3]);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            d4_push = 2'b11; d4_din[0] = 8'($urandom); d4_din[1] = 8'($urandom);
            d5_push[0] = 1'b1; d5_din[0] = 8'($urandom);
            tick();
        end
        #2;
        rst_ni = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            mo[k] = 1'b0;
            mu[k] = 1'b0;
        end
        for (int c = 0; c < 2; c++) begin
            n_vec++;
            if ({d4_full[c], d4_empty[c], d4_af[c], d4_ae[c], d4_ovf[c], d4_udf[c]} !== 6'b010100 ||
                d4_usage[c] !== 3'd0 || d4_dout[c] !== 8'h00) begin
                n_err++;
                $display("FAIL async_reset ch%0d flags=%b usage=%0d data=%h exp 010100/0/00", c,
                         {d4_full[c], d4_empty[c], d4_af[c], d4_ae[c], d4_ovf[c], d4_udf[c]},
                         d4_usage[c], d4_dout[c]);
            end
        end
        n_vec++;
        if (d5_usage[0] !== 4'd0 || d5_empty[0] !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset_d5 usage=%0d empty=%b exp 0/1", d5_usage[0], d5_empty[0]);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
    endtask

    initial begin
        clear_inputs();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        #1;
        test_reset();
        test_fill_drain();
        test_push_pop_full();
        test_flush();
        test_wrap_d5();
        test_fall_through();
        test_random();
        test_async_reset();
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
